router_pkt_tx: RTL and testbench

ROUTER_PKT_TX -- requirements
Module: router_pkt_tx

---
 rtl/router_pkt_tx.sv | 146 ++++++++++++++
 tb/tb_router_pkt_tx.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/router_pkt_tx.sv
// Packet transmitter: buffers up to 63 payload bytes, then frames them as
// header / payload / parity toward the router, honouring busy stalls.
module router_pkt_tx (
   input  logic       clock,
   input  logic       resetn,
   input  logic       ld_valid,
   input  logic [7:0] ld_data,
   output logic       ld_ready,
   input  logic       start,
   input  logic [1:0] dest,
   input  logic       busy,
   input  logic       error,
   output logic       pkt_valid,
   output logic [7:0] data_in,
   output logic       tx_done,
   output logic       tx_err,
   output logic       tx_reject,
   output logic       idle
);

   typedef enum logic [2:0] {IDLE, HEADER, PAYLOAD, PARITY, CHECK, DONE} state_t;

   state_t     state_q;
   logic [7:0] mem [0:62];
   logic [5:0] cnt_q;
   logic [5:0] len_q;
   logic [5:0] rd_ptr_q;
   logic [7:0] pxor_q;
   logic [7:0] hdr_q;
   logic [1:0] chk_q;
   logic       err_seen_q;
   logic       pkt_valid_q;
   logic [7:0] data_in_q;
   logic       tx_done_q;
   logic       tx_err_q;
   logic       tx_reject_q;

   logic       load;
   logic [5:0] cnt_d;
   logic [7:0] pxor_d;

   assign ld_ready = (state_q == IDLE) && (cnt_q != 6'd63);
   assign load     = ld_valid && ld_ready;
   // A load coinciding with start is folded in before the launch decision.
   assign cnt_d    = load ? cnt_q + 6'd1 : cnt_q;
   assign pxor_d   = load ? pxor_q ^ ld_data : pxor_q;

   assign pkt_valid = pkt_valid_q;
   assign data_in   = data_in_q;
   assign tx_done   = tx_done_q;
   assign tx_err    = tx_err_q;
   assign tx_reject = tx_reject_q;
   assign idle      = (state_q == IDLE);

   always_ff @(posedge clock) begin
      if (load) begin
         mem[cnt_q] <= ld_data;
      end
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_q     <= IDLE;
         cnt_q       <= 6'd0;
         len_q       <= 6'd0;
         rd_ptr_q    <= 6'd0;
         pxor_q      <= 8'd0;
         hdr_q       <= 8'd0;
         chk_q       <= 2'd0;
         err_seen_q  <= 1'b0;
         pkt_valid_q <= 1'b0;
         data_in_q   <= 8'd0;
         tx_done_q   <= 1'b0;
         tx_err_q    <= 1'b0;
         tx_reject_q <= 1'b0;
      end else begin
         tx_done_q   <= 1'b0;
         tx_reject_q <= 1'b0;
         case (state_q)
            IDLE: begin
               cnt_q  <= cnt_d;
               pxor_q <= pxor_d;
               if (start) begin
                  if (cnt_d == 6'd0 || dest == 2'd3) begin
                     tx_reject_q <= 1'b1;
                  end else begin
                     len_q       <= cnt_d;
                     hdr_q       <= {cnt_d, dest};
                     rd_ptr_q    <= 6'd0;
                     pkt_valid_q <= 1'b1;
                     data_in_q   <= {cnt_d, dest};
                     state_q     <= HEADER;
                  end
               end
            end
            HEADER: begin
               if (!busy) begin
                  data_in_q <= mem[6'd0];
                  state_q   <= PAYLOAD;
               end
            end
            PAYLOAD: begin
               // data_in is the read register, so fetch the next byte on consume.
               if (!busy) begin
                  rd_ptr_q <= rd_ptr_q + 6'd1;
                  if (rd_ptr_q == len_q - 6'd1) begin
                     pkt_valid_q <= 1'b0;
                     data_in_q   <= hdr_q ^ pxor_q;
                     state_q     <= PARITY;
                  end else begin
                     data_in_q <= mem[rd_ptr_q + 6'd1];
                  end
               end
            end
            PARITY: begin
               if (!busy) begin
                  data_in_q <= 8'd0;
                  chk_q     <= 2'd0;
                  state_q   <= CHECK;
               end
            end
            CHECK: begin
               err_seen_q <= err_seen_q | error;
               if (chk_q == 2'd2) begin
                  tx_done_q <= 1'b1;
                  tx_err_q  <= err_seen_q | error;
                  state_q   <= DONE;
               end else begin
                  chk_q <= chk_q + 2'd1;
               end
            end
            DONE: begin
               cnt_q      <= 6'd0;
               pxor_q     <= 8'd0;
               err_seen_q <= 1'b0;
               rd_ptr_q   <= 6'd0;
               state_q    <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_router_pkt_tx.sv
// Bench for router_pkt_tx: queue-based packet model compared every cycle,
// plus directed literal checks on the framed byte sequences.
module tb_router_pkt_tx;

   logic       clock = 1'b0;
   logic       resetn = 1'b0;
   logic       ld_valid = 1'b0;
   logic [7:0] ld_data = 8'd0;
   logic       start = 1'b0;
   logic [1:0] dest = 2'd0;
   logic       busy = 1'b0;
   logic       error = 1'b0;
   logic       ld_ready, pkt_valid, tx_done, tx_err, tx_reject, idle;
   logic [7:0] data_in;

   int checks = 0;
   int failures = 0;

   always #5 clock = ~clock;

   router_pkt_tx dut (
      .clock(clock), .resetn(resetn), .ld_valid(ld_valid), .ld_data(ld_data),
      .ld_ready(ld_ready), .start(start), .dest(dest), .busy(busy), .error(error),
      .pkt_valid(pkt_valid), .data_in(data_in), .tx_done(tx_done), .tx_err(tx_err),
      .tx_reject(tx_reject), .idle(idle)
   );

   // ---------------- behavioural model ----------------
   localparam int P_IDLE = 0, P_STREAM = 1, P_CHECK = 2, P_DONE = 3;
   logic [7:0] m_buf[$];
   logic [8:0] m_stream[$];   // {pkt_valid, byte} for every router-facing cycle
   int         m_phase = P_IDLE;
   int         m_idx = 0;
   int         m_wait = 0;
   int         m_len = 0;
   logic       m_err_seen = 1'b0;
   logic       m_done = 1'b0, m_err = 1'b0, m_rej = 1'b0;
   logic [7:0] m_hdr, m_par;

   always @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         m_buf.delete();
         m_stream.delete();
         m_phase = P_IDLE;
         m_idx = 0;
         m_wait = 0;
         m_err_seen = 1'b0;
         m_done = 1'b0;
         m_err = 1'b0;
         m_rej = 1'b0;
      end else begin
         m_done = 1'b0;
         m_rej = 1'b0;
         case (m_phase)
            P_IDLE: begin
               if (ld_valid && m_buf.size() < 63) m_buf.push_back(ld_data);
               if (start) begin
                  if (m_buf.size() == 0 || dest == 2'd3) begin
                     m_rej = 1'b1;
                  end else begin
                     m_len = m_buf.size();
                     m_hdr = {m_len[5:0], dest};
                     m_par = m_hdr;
                     m_stream.delete();
                     m_stream.push_back({1'b1, m_hdr});
                     foreach (m_buf[i]) begin
                        m_stream.push_back({1'b1, m_buf[i]});
                        m_par = m_par ^ m_buf[i];
                     end
                     m_stream.push_back({1'b0, m_par});
                     m_idx = 0;
                     m_phase = P_STREAM;
                  end
               end
            end
            P_STREAM: begin
               if (!busy) begin
                  m_idx++;
                  if (m_idx == m_stream.size()) begin
                     m_phase = P_CHECK;
                     m_wait = 0;
                  end
               end
            end
            P_CHECK: begin
               m_err_seen = m_err_seen | error;
               m_wait++;
               if (m_wait == 3) begin
                  m_done = 1'b1;
                  m_err = m_err_seen;
                  m_phase = P_DONE;
               end
            end
            default: begin
               m_buf.delete();
               m_err_seen = 1'b0;
               m_phase = P_IDLE;
            end
         endcase
      end
   end

   always @(negedge clock) begin
      logic [8:0] e;
      logic       e_idle, e_ready;
      e = (m_phase == P_STREAM) ? m_stream[m_idx] : 9'd0;
      e_idle = (m_phase == P_IDLE);
      e_ready = e_idle && (m_buf.size() < 63);
      checks++;
      if ({pkt_valid, data_in, tx_done, tx_err, tx_reject, idle, ld_ready} !==
          {e, m_done, m_err, m_rej, e_idle, e_ready}) begin
         failures++;
         $display("FAIL model_cmp t=%0t got pv=%b data=%02h done=%b err=%b rej=%b idle=%b rdy=%b want pv=%b data=%02h done=%b err=%b rej=%b idle=%b rdy=%b",
                  $time, pkt_valid, data_in, tx_done, tx_err, tx_reject, idle, ld_ready,
                  e[8], e[7:0], m_done, m_err, m_rej, e_idle, e_ready);
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic cyc();
      @(posedge clock);
      #2;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s t=%0t got=%0h want=%0h", nm, $time, act, exp);
      end else begin
         $display("ok   %s t=%0t value=%0h", nm, $time, act);
      end
   endtask

   task automatic step(input string nm, input logic pv, input logic [7:0] d);
      chk(nm, {23'd0, pkt_valid, data_in}, {23'd0, pv, d});
   endtask

   task automatic load(input logic [7:0] b);
      ld_valid = 1'b1;
      ld_data = b;
      cyc();
      ld_valid = 1'b0;
   endtask

   task automatic launch(input logic [1:0] d);
      start = 1'b1;
      dest = d;
      cyc();
      start = 1'b0;
   endtask

   task automatic wait_done(input string nm);
      int n;
      n = 0;
      while (tx_done !== 1'b1 && n < 200) begin
         cyc();
         n++;
      end
      chk(nm, {31'd0, tx_done}, 32'd1);
      cyc();
   endtask

   initial begin
      #400000;
      $display("FAIL global_timeout t=%0t", $time);
      $fatal(1, "timeout");
   end

   initial begin
      repeat (3) cyc();
      chk("reset_outputs", {pkt_valid, data_in, tx_done, tx_err, tx_reject}, 12'h000);
      resetn = 1'b1;
      chk("post_reset_ready_idle", {ld_ready, idle}, 2'b11);

      // basic packet
      load(8'h11); load(8'h22); load(8'h33);
      launch(2'd1);
      step("basic_hdr", 1, 8'h0D); cyc();
      step("basic_p0", 1, 8'h11); cyc();
      step("basic_p1", 1, 8'h22); cyc();
      step("basic_p2", 1, 8'h33); cyc();
      step("basic_par", 0, 8'h0D);
      repeat (4) cyc();
      chk("basic_done", {tx_done, tx_err}, 2'b10);
      cyc();
      chk("basic_back_idle", {tx_done, idle}, 2'b01);

      // stall on 0x22
      load(8'h11); load(8'h22); load(8'h33);
      launch(2'd1);
      step("stall_hdr", 1, 8'h0D); cyc();
      step("stall_p0", 1, 8'h11); cyc();
      step("stall_p1", 1, 8'h22);
      busy = 1'b1;
      repeat (3) begin
         cyc();
         step("stall_hold", 1, 8'h22);
      end
      busy = 1'b0;
      cyc();
      step("stall_p2", 1, 8'h33); cyc();
      step("stall_par", 0, 8'h0D);
      wait_done("stall_done");

      // rejects
      launch(2'd0);
      chk("rej_empty", {tx_reject, pkt_valid}, 2'b10);
      cyc();
      chk("rej_pulse_end", {31'd0, tx_reject}, 32'd0);
      load(8'hA5); load(8'h3C);
      launch(2'd3);
      chk("rej_dest3", {tx_reject, idle}, 2'b11);
      cyc();
      launch(2'd0);
      step("rej_retry_hdr", 1, 8'h08); cyc();
      step("rej_retry_p0", 1, 8'hA5); cyc();
      step("rej_retry_p1", 1, 8'h3C); cyc();
      step("rej_retry_par", 0, 8'h91);
      wait_done("rej_retry_done");

      // maximum length
      for (int i = 0; i < 63; i++) load(i[7:0]);
      chk("max_full_ready", {31'd0, ld_ready}, 32'd0);
      ld_valid = 1'b1;
      ld_data = 8'hEE;
      cyc();
      ld_valid = 1'b0;
      launch(2'd2);
      step("max_hdr", 1, 8'hFE);
      for (int i = 0; i < 63; i++) begin
         cyc();
         if (pkt_valid !== 1'b1 || data_in !== i[7:0]) begin
            step("max_payload", 1, i[7:0]);
         end
      end
      cyc();
      step("max_par", 0, 8'hC1);
      wait_done("max_done");

      // error report
      load(8'h5A);
      launch(2'd1);
      step("err_hdr", 1, 8'h05); cyc();
      step("err_p0", 1, 8'h5A); cyc();
      step("err_par", 0, 8'h5F);
      cyc(); cyc();
      error = 1'b1;
      cyc();
      error = 1'b0;
      cyc();
      chk("err_done", {tx_done, tx_err}, 2'b11);
      cyc();
      chk("err_held", {tx_done, tx_err}, 2'b01);
      load(8'h01);
      launch(2'd2);
      step("clean_hdr", 1, 8'h06);
      wait_done("clean_done");
      chk("clean_err", {31'd0, tx_err}, 32'd0);

      // reset mid-payload
      for (int i = 0; i < 5; i++) load(8'h10 + i[7:0]);
      launch(2'd1);
      cyc();
      cyc();
      step("rst_byte2", 1, 8'h11);
      #1 resetn = 1'b0;
      #1 chk("rst_immediate", {pkt_valid, data_in, idle}, 10'h001);
      cyc();
      resetn = 1'b1;
      chk("rst_release", {ld_ready, idle}, 2'b11);
      launch(2'd0);
      chk("rst_cnt_zero_reject", {31'd0, tx_reject}, 32'd1);
      cyc();
      load(8'h77);
      launch(2'd1);
      step("rst_fresh_hdr", 1, 8'h05);
      wait_done("rst_fresh_done");

      repeat (2) cyc();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
